// File: rtl/binary_divider_pkg.sv
// Shared definitions for the restoring shift-subtract divider.
package binary_divider_pkg;

  // Controller state encodings
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Width of the iteration counter for a 2*width-bit dividend
  function automatic int iter_cnt_width(input int width);
    return $clog2(2 * width) + 1;
  endfunction

endpackage

// File: rtl/binary_divider_step.sv
// One restoring iteration: shift {P,Q} left by one, trial-subtract the divisor
// from P and keep the difference only when it does not borrow.
// P is held in WIDTH bits between iterations because it is always below the
// divisor; the shifted value is widened to WIDTH+1 bits for the comparison.
module binary_divider_step
  import binary_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]   p_in,
  input  logic [2*WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0]   divisor,
  output logic [WIDTH-1:0]   p_out,
  output logic [2*WIDTH-1:0] q_out
);

  logic [WIDTH:0]   p_shift_s;
  logic [WIDTH-1:0] diff_s;
  logic             fits_s;

  // Shift, trial subtract and select the restored or reduced partial remainder
  always_comb begin
    p_shift_s = {p_in, q_in[2*WIDTH-1]};
    fits_s    = (p_shift_s >= {1'b0, divisor});
    // A non-borrowing difference is below the divisor, so WIDTH bits suffice
    diff_s    = p_shift_s[WIDTH-1:0] - divisor;
    if (fits_s) begin
      p_out = diff_s;
      q_out = {q_in[2*WIDTH-2:0], 1'b1};
    end else begin
      p_out = p_shift_s[WIDTH-1:0];
      q_out = {q_in[2*WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/binary_divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock, start/busy/done handshake.
module binary_divider
  import binary_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic [2*WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero
);

  localparam int CNT_W = iter_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(2 * WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t               state_r;
  logic [WIDTH-1:0]     p_r;
  logic [2*WIDTH-1:0]   q_r;
  logic [WIDTH-1:0]     dvs_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [WIDTH-1:0]     p_next_s;
  logic [2*WIDTH-1:0]   q_next_s;

  binary_divider_step #(.WIDTH(WIDTH)) u_step (
    .p_in    (p_r),
    .q_in    (q_r),
    .divisor (dvs_r),
    .p_out   (p_next_s),
    .q_out   (q_next_s)
  );

  // Controller FSM, operand capture, iteration and registered results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      p_r         <= {WIDTH{1'b0}};
      q_r         <= {(2*WIDTH){1'b0}};
      dvs_r       <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      quotient    <= {(2*WIDTH){1'b0}};
      remainder   <= {WIDTH{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        // IDLE and DONE accept a new request identically (back-to-back)
        S_IDLE, S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
          if (start) begin
            if (divisor == {WIDTH{1'b0}}) begin
              // No iteration: publish the fixed div-by-zero result directly
              quotient    <= {(2*WIDTH){1'b1}};
              remainder   <= dividend[WIDTH-1:0];
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state_r     <= S_DONE;
            end else begin
              p_r     <= {WIDTH{1'b0}};
              q_r     <= dividend;
              dvs_r   <= divisor;
              cnt_r   <= {CNT_W{1'b0}};
              busy    <= 1'b1;
              state_r <= S_CALC;
            end
          end
        end
        S_CALC: begin
          p_r   <= p_next_s;
          q_r   <= q_next_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == LAST_ITER) begin
            quotient    <= q_next_s;
            remainder   <= p_next_s;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state_r     <= S_DONE;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_binary_divider.sv
// Self-checking bench for binary_divider (WIDTH=4): directed table, handshake
// corner sequences and random operands against an arithmetic reference.
module tb_binary_divider;

  localparam int W = 4;

  logic           clk;
  logic           rst;
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic [2*W-1:0] quotient;
  logic [W-1:0]   remainder;
  logic           busy;
  logic           done;
  logic           div_by_zero;

  int total  = 0;
  int passed = 0;

  int last_q  = 0;
  int last_r  = 0;
  int last_dz = 0;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dz;
  } vec_t;

  vec_t vecs[8];

  binary_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: plain integer division, fixed result for a zero divisor
  task automatic model(input int a, input int b, output int q, output int r, output int dz);
    if (b == 0) begin
      q = 255; r = a % 16; dz = 1;
    end else begin
      q = a / b; r = a % b; dz = 0;
    end
  endtask

  // One complete operation with a one-cycle start pulse
  task automatic do_op(input int a, input int b, input int eq, input int er, input int edz,
                       input string name);
    int cycles;
    int busy_cnt;
    @(negedge clk);
    dividend = a[2*W-1:0];
    divisor  = b[W-1:0];
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    // Scramble inputs: captured operands must be used
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    if (edz == 0) begin
      chk({name, "_hold_q"}, int'(quotient), last_q);
      chk({name, "_hold_r"}, int'(remainder), last_r);
    end
    cycles   = 1;
    busy_cnt = 0;
    while (!done && cycles < 30) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
    chk({name, "_latency"}, cycles, (edz != 0) ? 1 : 9);
    chk({name, "_busy_cycles"}, busy_cnt, (edz != 0) ? 0 : 8);
    chk({name, "_busy_at_done"}, int'(busy), 0);
    chk({name, "_q"}, int'(quotient), eq);
    chk({name, "_r"}, int'(remainder), er);
    chk({name, "_dz"}, int'(div_by_zero), edz);
    last_q  = eq;
    last_r  = er;
    last_dz = edz;
  endtask

  initial begin
    int q, r, dz, cnt, pulses, x, y, a, b;
    bit prev_done;

    vecs[0] = '{30, 3, 10, 0, 0};
    vecs[1] = '{255, 15, 17, 0, 0};
    vecs[2] = '{100, 7, 14, 2, 0};
    vecs[3] = '{7, 9, 0, 7, 0};
    vecs[4] = '{255, 1, 255, 0, 0};
    vecs[5] = '{8'h5A, 0, 8'hFF, 4'hA, 1};
    vecs[6] = '{8'h5A, 2, 45, 0, 0};
    vecs[7] = '{0, 5, 0, 0, 0};

    rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk("reset_q", int'(quotient), 0);
    chk("reset_r", int'(remainder), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_dz", int'(div_by_zero), 0);
    rst = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 8; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, $sformatf("vec%0d", i));

    // Start held high for 20 cycles, operands changed in CALC cycle 3
    @(negedge clk);
    dividend = 8'd30; divisor = 4'd3; start = 1'b1;
    pulses = 0; prev_done = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) pulses++;
      chk($sformatf("held_done_c%0d", i), int'(done), (i == 9 || i == 18) ? 1 : 0);
      if (done && prev_done) chk("held_consecutive_done", 1, 0);
      prev_done = done;
      if (i == 9) begin
        chk("held_first_q", int'(quotient), 10);
        chk("held_first_r", int'(remainder), 0);
      end
      if (i == 18) begin
        chk("held_second_q", int'(quotient), 14);
        chk("held_second_r", int'(remainder), 2);
      end
      if (i == 3) begin dividend = 8'd100; divisor = 4'd7; end
    end
    start = 1'b0;
    chk("held_pulse_count", pulses, 2);
    cnt = 0;
    while (!done && cnt < 20) begin @(negedge clk); cnt++; end
    chk("held_third_wait", cnt, 7);
    chk("held_third_q", int'(quotient), 14);
    chk("held_third_r", int'(remainder), 2);
    last_q = 14; last_r = 2; last_dz = 0;

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    dividend = 8'd30; divisor = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_q", int'(quotient), 0);
    chk("midrst_r", int'(remainder), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_dz", int'(div_by_zero), 0);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("midrst_quiet_cycles", cnt, 0);
    last_q = 0; last_r = 0; last_dz = 0;
    do_op(200, 9, 22, 2, 0, "after_rst");

    // Results hold while idle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("idle_hold_c%0d", i),
          int'(quotient == 8'd22 && remainder == 4'd2 && !done && !busy), 1);
    end

    // Random operands against the reference
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 15);
      model(a, b, q, r, dz);
      do_op(a, b, q, r, dz, $sformatf("rnd%0d", i));
    end

    // Multiplier round trip: (x*y)/y returns x with zero remainder
    for (int i = 0; i < 10; i++) begin
      x = $urandom_range(0, 15);
      y = $urandom_range(1, 15);
      do_op(x * y, y, x, 0, 0, $sformatf("trip%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
